ex_div_seq: RTL and testbench

Iterative RV32M divide/remainder unit in the EX stage of `risc_v_top`. It consumes operands leaving the ID/EX pipeline register and produces one result for the EX/MEM pipeline register. While a division is in flight, it drives a stall that deasserts `i_en` on the upstream pipeline registers. It implements DIV, DIVU, REM and REMU as a restoring divider, one quotient bit per cycle.

---
 rtl/div_pkg.sv | 29 ++
 rtl/div_step.sv | 29 ++
 rtl/ex_div_seq.sv | 170 +++++++++++++++++
 tb/tb_ex_div_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV32M divider: op encodings, FSM states,
// default operand width and small op-decoding helpers.
package div_pkg;

    localparam int DIV_XLEN = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } div_state_t;

    function automatic logic op_is_signed(input div_op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the
// divisor, keep the difference and set the quotient LSB when it is non-negative.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_next,
    output logic [XLEN-1:0] quo_next
);

    // One spare bit above the partial remainder makes the borrow an explicit sign bit.
    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;

    assign shifted = {rem, quo[XLEN-1]};
    assign diff    = shifted - {2'b00, divisor};

    always_comb begin
        rem_next = shifted[XLEN:0];
        quo_next = {quo[XLEN-2:0], 1'b0};
        if (!diff[XLEN+1]) begin
            rem_next = diff[XLEN:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/ex_div_seq.sv
// EX-stage RV32M DIV/DIVU/REM/REMU unit, restoring, one quotient bit per cycle.
// Optional DIV_FASTPATH_EN: divide-by-zero and signed overflow finish straight from IDLE.
module ex_div_seq
    import div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_stall,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

`ifdef DIV_FASTPATH_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    div_state_t state_reg, state_next;

    logic            rem_sel_reg;
    logic            neg_quo_reg;
    logic            neg_rem_reg;
    logic            dz_reg;
    logic            ovf_reg;
    logic [XLEN-1:0] rs1_reg;
    logic [XLEN-1:0] divisor_reg;
    logic [XLEN:0]   rem_reg;
    logic [XLEN-1:0] quo_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [XLEN-1:0] result_reg;

    div_op_t         op_in;
    logic            in_signed;
    logic            rs1_neg_in;
    logic            rs2_neg_in;
    logic [XLEN-1:0] abs_rs1;
    logic [XLEN-1:0] abs_rs2;
    logic            dz_in;
    logic            ovf_in;
    logic            special_in;
    logic            accept;
    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] fix_result;

    // RISC-V mandated results; only divide-by-zero and signed overflow reach here.
    function automatic logic [XLEN-1:0] special_value(input logic is_rem,
                                                      input logic dz,
                                                      input logic [XLEN-1:0] rs1);
        if (dz)
            return is_rem ? rs1 : '1;
        return is_rem ? '0 : MIN_NEG;
    endfunction

    assign op_in      = div_op_t'(i_op);
    assign in_signed  = op_is_signed(op_in);
    assign rs1_neg_in = in_signed & i_rs1[XLEN-1];
    assign rs2_neg_in = in_signed & i_rs2[XLEN-1];
    assign abs_rs1    = rs1_neg_in ? -i_rs1 : i_rs1;
    assign abs_rs2    = rs2_neg_in ? -i_rs2 : i_rs2;
    assign dz_in      = (i_rs2 == '0);
    assign ovf_in     = in_signed && (i_rs1 == MIN_NEG) && (i_rs2 == '1);
    assign special_in = dz_in | ovf_in;
    assign accept     = (state_reg == ST_IDLE) && i_start && !i_flush;

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_reg),
        .quo      (quo_reg),
        .divisor  (divisor_reg),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic; flush wins over everything
    always_comb begin
        state_next = state_reg;
        if (i_flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (i_start) state_next = (FAST_EN && special_in) ? ST_DONE : ST_CALC;
                ST_CALC: if (cnt_reg == '0) state_next = ST_FIX;
                ST_FIX:  state_next = ST_DONE;
                ST_DONE: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Outputs; stall covers the start cycle so upstream holds from the first cycle
    always_comb begin
        o_busy  = (state_reg == ST_CALC) || (state_reg == ST_FIX);
        o_stall = accept || (state_reg == ST_CALC) || (state_reg == ST_FIX);
        o_valid = (state_reg == ST_DONE);
    end

    assign o_result = result_reg;

    always_comb begin
        fix_result = '0;
        if (dz_reg || ovf_reg)
            fix_result = special_value(rem_sel_reg, dz_reg, rs1_reg);
        else if (rem_sel_reg)
            fix_result = neg_rem_reg ? -rem_reg[XLEN-1:0] : rem_reg[XLEN-1:0];
        else
            fix_result = neg_quo_reg ? -quo_reg : quo_reg;
    end

    // Datapath: operand capture, iteration and the result register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rem_sel_reg <= 1'b0;
            neg_quo_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            dz_reg      <= 1'b0;
            ovf_reg     <= 1'b0;
            rs1_reg     <= '0;
            divisor_reg <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            cnt_reg     <= '0;
            result_reg  <= '0;
        end else if (accept) begin
            rem_sel_reg <= op_is_rem(op_in);
            neg_quo_reg <= rs1_neg_in ^ rs2_neg_in;
            neg_rem_reg <= rs1_neg_in;
            dz_reg      <= dz_in;
            ovf_reg     <= ovf_in;
            rs1_reg     <= i_rs1;
            divisor_reg <= abs_rs2;
            rem_reg     <= '0;
            quo_reg     <= abs_rs1;
            cnt_reg     <= CNT_W'(XLEN - 1);
            if (FAST_EN && special_in)
                result_reg <= special_value(op_is_rem(op_in), dz_in, i_rs1);
        end else if (!i_flush) begin
            case (state_reg)
                ST_CALC: begin
                    rem_reg <= step_rem;
                    quo_reg <= step_quo;
                    if (cnt_reg != '0)
                        cnt_reg <= cnt_reg - CNT_W'(1);
                end
                ST_FIX:  result_reg <= fix_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div_seq.sv
// Directed bench for ex_div_seq: a driver issues ops and pushes expected results,
// a monitor pops and compares result and arrival edge whenever o_valid is seen.
module tb_ex_div_seq;

    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;

    // Edges from the start-sampling edge to the edge after which o_valid is high.
    localparam int LAT = 33;
`ifdef DIV_FASTPATH_EN
    localparam int LAT_SP = 0;
`else
    localparam int LAT_SP = 33;
`endif

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic        i_flush;
    logic        o_busy;
    logic        o_stall;
    logic        o_valid;
    logic [31:0] o_result;

    typedef struct {
        logic [31:0] res;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;

    ex_div_seq dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_op     (i_op),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_flush  (i_flush),
        .o_busy   (o_busy),
        .o_stall  (o_stall),
        .o_valid  (o_valid),
        .o_result (o_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (o_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_valid: got o_valid=1 result=%h, required no o_valid", o_result);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_result"}, o_result, e.res);
                    check({e.name, "_edge"}, cyc, e.due);
                    $display("op %-12s result=%h edge=%0d", e.name, o_result, cyc);
                end
            end
        end
    end

    // Issue one op (entered 1 time unit after a rising edge) and follow it to o_valid.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string name);
        exp_t e;
        int   n;
        int   st;
        i_op    = op;
        i_rs1   = a;
        i_rs2   = b;
        i_start = 1'b1;
        #1;
        check({name, "_stall_start"}, 32'(o_stall), 32'd1);
        e.res  = exp;
        e.due  = cyc + 1 + lat;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        i_start = 1'b0;
        n  = 0;
        st = 0;
        while (!o_valid && n < 100) begin
            if (o_stall) st++;
            n++;
            @(posedge clk);
            #1;
        end
        check({name, "_timeout"}, 32'(n >= 100), 32'd0);
        check({name, "_stall_cycles"}, st, lat);
        check({name, "_stall_done"}, 32'(o_stall), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_op    = DIV;
        i_rs1   = '0;
        i_rs2   = '0;
        i_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   32'(o_busy),  32'd0);
        check("reset_stall",  32'(o_stall), 32'd0);
        check("reset_valid",  32'(o_valid), 32'd0);
        check("reset_result", o_result,     32'd0);
        i_rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(DIVU, 32'd100, 32'd7, 32'd14, LAT, "divu_100_7");
        run_op(REMU, 32'd100, 32'd7, 32'd2,  LAT, "remu_100_7");
        run_op(DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT, "div_m7_2");
        run_op(REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT, "rem_m7_2");
        run_op(DIV,  32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, LAT, "div_20_m3");
        run_op(REM,  32'd20, 32'hFFFF_FFFD, 32'd2,        LAT, "rem_20_m3");
        run_op(DIV,  32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'd6,        LAT, "div_m20_m3");
        run_op(REM,  32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, LAT, "rem_m20_m3");
        run_op(DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, LAT, "divu_max_1");
        run_op(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT, "divu_min_max");

        run_op(DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SP, "div_5_0");
        run_op(DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SP, "divu_5_0");
        run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SP, "div_ovf");
        run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_SP, "rem_ovf");
        run_op(REM,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, LAT_SP, "rem_m7_0");
        run_op(REMU, 32'd5, 32'd0, 32'd5, LAT_SP, "remu_5_0");

        // Start together with flush in IDLE must be ignored.
        i_op    = DIVU;
        i_rs1   = 32'd50;
        i_rs2   = 32'd5;
        i_start = 1'b1;
        i_flush = 1'b1;
        #1;
        check("flush_start_stall", 32'(o_stall), 32'd0);
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_flush = 1'b0;
        check("flush_start_busy", 32'(o_busy), 32'd0);
        $display("op flush_start busy=%0d", o_busy);
        repeat (3) @(posedge clk);
        #1;

        // Flush on the 10th CALC cycle.
        i_op    = DIVU;
        i_rs1   = 32'd1000;
        i_rs2   = 32'd3;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("flush_busy_before", 32'(o_busy), 32'd1);
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        check("flush_busy_after",  32'(o_busy),  32'd0);
        check("flush_stall_after", 32'(o_stall), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("flush_result_held", o_result, 32'd5);
        $display("op flush_calc result=%h", o_result);
        run_op(DIVU, 32'd9, 32'd3, 32'd3, LAT, "divu_9_3");

        // Reset pulsed mid-CALC.
        i_op    = DIV;
        i_rs1   = 32'd1000;
        i_rs2   = 32'd7;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        i_rst = 1'b1;
        #1;
        check("midrst_busy",   32'(o_busy),  32'd0);
        check("midrst_stall",  32'(o_stall), 32'd0);
        check("midrst_valid",  32'(o_valid), 32'd0);
        check("midrst_result", o_result,     32'd0);
        $display("op mid_reset result=%h busy=%0d", o_result, o_busy);
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        @(posedge clk);
        #1;
        run_op(DIV, 32'd1000, 32'd7, 32'd142, LAT, "div_1000_7");
        run_op(REM, 32'd1000, 32'd7, 32'd6,   LAT, "rem_1000_7");

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
